debug_dump_reader: RTL and testbench
====================================

Name: debug_dump_reader

Overview:
- Host-side counterpart of the core's debug port. The core answers a debug address with a debug data word; this block is the reader that drives those addresses and captures the answers.
- On a start pulse it freezes the core, sweeps debug_addr over a configured range, and captures each debug_data word.
- Each captured word is streamed out as bytes over a valid/ready byte interface; a UART TX sits downstream.
- When not dumping, it also generates single-step pulses for the core.

Parameters:
- ADDR_FIRST, 0, first debug address swept.
- ADDR_LAST, 63, last debug address swept: regs 0-31, then test signals 32-63.
- SETTLE_CYCLES, 2, wait cycles after driving debug_addr before capture (1..15).
- STEP_PULSE, 1, width in cycles of each debug_step pulse (1..15).

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a dump.
- halt  in  1  level; user freeze request, passed to debug_en.
- step_req  in  1  one-cycle pulse; requests one core step.
- debug_en  out  1  to core; equals halt OR busy.
- debug_step  out  1  to core step-clock input.
- debug_addr  out  7  to core debug address.
- debug_data  in  32  from core; combinational function of debug_addr.
- tx_data  out  8  byte to downstream sink.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  sink accepts the byte this cycle.
- busy  out  1  dump in progress.
- done  out  1  one-cycle pulse when the dump completes.

Behaviour:
- Reset: state IDLE; debug_addr=ADDR_FIRST; tx_data=0; tx_valid=0; busy=0; done=0; debug_step=0; all counters 0. Reset mid-dump aborts immediately; no partial byte completes.
- IDLE:
  - start=1 -> SETADDR, with debug_addr=ADDR_FIRST and busy=1.
  - step_req=1 with start=0 -> debug_step high for STEP_PULSE cycles, then low.
  - step_req during an active step pulse, or start and step_req in the same cycle: the step request is dropped.
- SETADDR (1 cycle): debug_addr holds its value; settle counter loads SETTLE_CYCLES -> SETTLE.
- SETTLE: counter decrements each cycle; when it reaches 1 -> CAPTURE.
- CAPTURE (1 cycle): word register <= debug_data; byte index=0 -> SEND.
- SEND:
  - tx_valid=1; tx_data = word byte (3 - idx). Big-endian, MSB first.
  - tx_data and tx_valid stay stable until tx_ready=1. A transfer occurs on a clock edge where tx_valid and tx_ready are both 1.
  - After a transfer on idx<3: idx++, and tx_valid stays 1 (back-to-back bytes allowed).
  - After the transfer on idx=3: tx_valid=0 -> NEXT.
- NEXT (1 cycle):
  - debug_addr==ADDR_LAST -> DONE.
  - Otherwise debug_addr+1 -> SETADDR.
  - debug_addr does not wrap past 127 (ADDR_LAST<=127 is enforced by elaboration assertion).
- DONE (1 cycle): done=1; busy=0 on the next cycle; debug_addr returns to ADDR_FIRST -> IDLE.
- start while busy is ignored. debug_step is forced 0 while busy.
- Timing with tx_ready held 1, per word: 1 (SETADDR) + SETTLE_CYCLES + 1 (CAPTURE) + 4 (SEND) + 1 (NEXT) cycles. With defaults this is 9 cycles/word, and a 64-word dump takes 576 cycles + 1 DONE cycle.
- debug_en is combinational: halt | busy. The core is frozen for the whole dump, so debug_data is stable during settle and capture.

Optional Feature:
- Macro DEBUG_DUMP_FRAME_EN.
- Defined:
  - Before the first word, send header bytes 0xA5 then 0x5A (states HDR0, HDR1, same valid/ready rules).
  - After the last word, before DONE, send one checksum byte: the XOR of every data byte sent (header bytes excluded).
  - Dump length becomes 4*N+3 bytes.
- Undefined: exactly 4*N data bytes, no header, no checksum state or logic.

Decomposition:
- Shared package debug_pkg:
  - state enum (IDLE, SETADDR, SETTLE, CAPTURE, SEND, NEXT, DONE, HDR0, HDR1, CKSUM).
  - constants DBG_HDR0=8'hA5, DBG_HDR1=8'h5A, DBG_ADDR_W=7.
- One sub-module, debug_byte_serializer: a 32-bit word in, a load strobe, valid/ready byte out with MSB-first index; it also holds the running XOR when framing is enabled.
- The FSM, address counter and step-pulse generator stay in the top module.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> outputs at reset values immediately; debug_addr=0, tx_valid=0, busy=0.
- Full dump: model returns debug_data={8'hDE,8'hAD,1'b0,debug_addr,8'h00}; tx_ready=1; pulse start -> 256 bytes, the first word being DE AD 00 00 and the last DE AD 3F 00. done asserts on cycle 577 after start; debug_en=1 throughout.
- Backpressure: tx_ready toggles 1010..., or is held low 20 cycles mid-word -> tx_data stable while stalled, no byte duplicated or lost, same 256-byte sequence.
- Start while busy / step during dump: extra start at cycle 100 and step_req at cycle 150 -> ignored, debug_step stays 0, byte count unchanged.
- Reset mid-dump: rst at byte 50 -> tx_valid falls at once; a new start afterwards yields a complete 256-byte dump starting at address 0.
- Framing with DEBUG_DUMP_FRAME_EN, ADDR_FIRST=ADDR_LAST=5, debug_data=32'h12345678 -> A5 5A 12 34 56 78 08 (checksum 0x12^0x34^0x56^0x78=0x08).

Source files
------------

// File: rtl/debug_pkg.sv
// ============================================================================
// Module : debug_pkg
// Brief  : Shared state encoding and constants for the debug dump reader.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package debug_pkg;

    localparam int        DBG_ADDR_W = 7;
    localparam logic [7:0] DBG_HDR0  = 8'hA5;
    localparam logic [7:0] DBG_HDR1  = 8'h5A;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        SETADDR = 4'd1,
        SETTLE  = 4'd2,
        CAPTURE = 4'd3,
        SEND    = 4'd4,
        NEXT    = 4'd5,
        DONE    = 4'd6,
        HDR0    = 4'd7,
        HDR1    = 4'd8,
        CKSUM   = 4'd9
    } dbg_state_t;

endpackage

`default_nettype wire

// File: rtl/debug_byte_serializer.sv
// ============================================================================
// Module : debug_byte_serializer
// Brief  : Splits a 32-bit word into MSB-first bytes on a valid/ready port.
//          With DEBUG_DUMP_FRAME_EN it also sends single bytes and keeps the
//          running XOR of all word bytes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module debug_byte_serializer
    import debug_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_word_load,
    input  logic [31:0] i_word,
`ifdef DEBUG_DUMP_FRAME_EN
    input  logic        i_byte_load,
    input  logic [7:0]  i_byte,
    input  logic        i_cksum_clr,
    output logic [7:0]  o_cksum,
`endif
    input  logic        i_tx_ready,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    output logic        o_fin
);

    logic [31:0] r_word;
    logic [1:0]  r_idx;
    logic        r_valid;
    logic        w_xfer;
    logic        w_last;

    assign w_xfer     = r_valid & i_tx_ready;
    assign o_tx_valid = r_valid;
    assign o_fin      = w_xfer & w_last;

    always_comb begin
        o_tx_data = r_word[31:24];
        case (r_idx)
            2'd1:    o_tx_data = r_word[23:16];
            2'd2:    o_tx_data = r_word[15:8];
            2'd3:    o_tx_data = r_word[7:0];
            default: o_tx_data = r_word[31:24];
        endcase
    end

`ifdef DEBUG_DUMP_FRAME_EN
    // Single bytes (header/checksum) sit in the top lane and end after one transfer.
    logic       r_single;
    logic [7:0] r_xor;

    assign w_last  = r_single | (r_idx == 2'd3);
    assign o_cksum = r_xor;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_xor <= 8'h00;
        end else if (i_cksum_clr) begin
            r_xor <= 8'h00;
        end else if (w_xfer && !r_single) begin
            r_xor <= r_xor ^ o_tx_data;
        end
    end
`else
    assign w_last = (r_idx == 2'd3);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word  <= 32'h0;
            r_idx   <= 2'd0;
            r_valid <= 1'b0;
`ifdef DEBUG_DUMP_FRAME_EN
            r_single <= 1'b0;
`endif
        end else if (i_word_load) begin
            r_word  <= i_word;
            r_idx   <= 2'd0;
            r_valid <= 1'b1;
`ifdef DEBUG_DUMP_FRAME_EN
            r_single <= 1'b0;
        end else if (i_byte_load) begin
            r_word   <= {i_byte, 24'h0};
            r_idx    <= 2'd0;
            r_valid  <= 1'b1;
            r_single <= 1'b1;
`endif
        end else if (w_xfer) begin
            if (w_last) begin
                r_valid <= 1'b0;
            end else begin
                r_idx <= r_idx + 2'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/debug_dump_reader.sv
// ============================================================================
// Module : debug_dump_reader
// Brief  : Freezes the core, sweeps debug_addr, streams each captured word as
//          bytes; generates single-step pulses when idle.
// Build  : define DEBUG_DUMP_FRAME_EN for A5 5A header and XOR checksum byte.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module debug_dump_reader
    import debug_pkg::*;
#(
    parameter int ADDR_FIRST    = 0,
    parameter int ADDR_LAST     = 63,
    parameter int SETTLE_CYCLES = 2,
    parameter int STEP_PULSE    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  halt,
    input  logic                  step_req,
    output logic                  debug_en,
    output logic                  debug_step,
    output logic [DBG_ADDR_W-1:0] debug_addr,
    input  logic [31:0]           debug_data,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  done
);

    localparam logic [DBG_ADDR_W-1:0] c_addr_first = DBG_ADDR_W'(ADDR_FIRST);
    localparam logic [DBG_ADDR_W-1:0] c_addr_last  = DBG_ADDR_W'(ADDR_LAST);
    localparam logic [3:0]            c_settle     = 4'(SETTLE_CYCLES);
    localparam logic [3:0]            c_step       = 4'(STEP_PULSE);

    if (ADDR_LAST > 127 || ADDR_FIRST < 0 || ADDR_FIRST > ADDR_LAST) begin : g_chk_addr
        $error("debug_dump_reader: address range must satisfy 0 <= ADDR_FIRST <= ADDR_LAST <= 127");
    end
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_chk_settle
        $error("debug_dump_reader: SETTLE_CYCLES must be 1..15");
    end
    if (STEP_PULSE < 1 || STEP_PULSE > 15) begin : g_chk_step
        $error("debug_dump_reader: STEP_PULSE must be 1..15");
    end

    dbg_state_t            r_state;
    logic [DBG_ADDR_W-1:0] r_addr;
    logic [3:0]            r_settle;
    logic [3:0]            r_step_cnt;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_step;
    logic                  w_fin;
    logic                  w_word_load;
    logic                  w_last_addr;

    assign w_word_load = (r_state == CAPTURE);
    assign w_last_addr = (r_addr == c_addr_last);

    assign debug_en   = halt | r_busy;
    assign debug_step = r_step;
    assign debug_addr = r_addr;
    assign busy       = r_busy;
    assign done       = r_done;

`ifdef DEBUG_DUMP_FRAME_EN
    logic       w_byte_load;
    logic [7:0] w_byte;
    logic [7:0] w_cksum;
    logic       w_cksum_clr;

    assign w_cksum_clr = (r_state == IDLE) & start;

    always_comb begin
        w_byte_load = 1'b0;
        w_byte      = DBG_HDR0;
        case (r_state)
            IDLE:    w_byte_load = start;
            HDR0: begin
                w_byte_load = w_fin;
                w_byte      = DBG_HDR1;
            end
            NEXT: begin
                w_byte_load = w_last_addr;
                w_byte      = w_cksum;
            end
            default: w_byte_load = 1'b0;
        endcase
    end
`endif

    debug_byte_serializer u_ser (
        .clk         (clk),
        .rst         (rst),
        .i_word_load (w_word_load),
        .i_word      (debug_data),
`ifdef DEBUG_DUMP_FRAME_EN
        .i_byte_load (w_byte_load),
        .i_byte      (w_byte),
        .i_cksum_clr (w_cksum_clr),
        .o_cksum     (w_cksum),
`endif
        .i_tx_ready  (tx_ready),
        .o_tx_data   (tx_data),
        .o_tx_valid  (tx_valid),
        .o_fin       (w_fin)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_addr   <= c_addr_first;
            r_settle <= 4'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_addr <= c_addr_first;
                        r_busy <= 1'b1;
`ifdef DEBUG_DUMP_FRAME_EN
                        r_state <= HDR0;
`else
                        r_state <= SETADDR;
`endif
                    end
                end
`ifdef DEBUG_DUMP_FRAME_EN
                HDR0:  if (w_fin) r_state <= HDR1;
                HDR1:  if (w_fin) r_state <= SETADDR;
                CKSUM: begin
                    if (w_fin) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
`endif
                SETADDR: begin
                    r_settle <= c_settle;
                    r_state  <= SETTLE;
                end
                SETTLE: begin
                    r_settle <= r_settle - 4'd1;
                    if (r_settle == 4'd1) r_state <= CAPTURE;
                end
                CAPTURE: r_state <= SEND;
                SEND:    if (w_fin) r_state <= NEXT;
                NEXT: begin
                    if (w_last_addr) begin
`ifdef DEBUG_DUMP_FRAME_EN
                        r_state <= CKSUM;
`else
                        r_state <= DONE;
                        r_done  <= 1'b1;
`endif
                    end else begin
                        r_addr  <= r_addr + DBG_ADDR_W'(1);
                        r_state <= SETADDR;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_addr  <= c_addr_first;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Steps are only honoured from IDLE; a start always kills a pending pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step     <= 1'b0;
            r_step_cnt <= 4'd0;
        end else if (r_state == IDLE && start) begin
            r_step     <= 1'b0;
            r_step_cnt <= 4'd0;
        end else if (r_step) begin
            r_step_cnt <= r_step_cnt - 4'd1;
            if (r_step_cnt == 4'd1) r_step <= 1'b0;
        end else if (r_state == IDLE && step_req) begin
            r_step     <= 1'b1;
            r_step_cnt <= c_step;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_debug_dump_reader.sv
// ============================================================================
// Module : tb_debug_dump_reader
// Brief  : Self-checking bench: step table, full dumps under several ready
//          patterns against a byte-stream model, reset mid-dump, framing.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_debug_dump_reader;
    import debug_pkg::*;

    localparam int LO     = 0;
    localparam int HI     = 63;
    localparam int SETTLE = 2;
`ifdef DEBUG_DUMP_FRAME_EN
    localparam bit FRAME = 1'b1;
`else
    localparam bit FRAME = 1'b0;
`endif
    localparam int WORDS = HI - LO + 1;
    localparam int LAT   = WORDS * (1 + SETTLE + 1 + 4 + 1) + 1 + (FRAME ? 3 : 0);

    logic        clk = 1'b0;
    logic        rst, start, halt, step_req, tx_ready;
    logic        debug_en, debug_step, tx_valid, busy, done;
    logic [6:0]  debug_addr;
    logic [31:0] debug_data;
    logic [7:0]  tx_data;

    logic [31:0] mem [0:127];
    logic [7:0]  got[$];
    logic [7:0]  exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          ready_mode = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    typedef struct {
        logic step;
        logic hlt;
        logic exp_step;
        logic exp_en;
    } vec_t;
    vec_t tbl [10];

    always #5 clk = ~clk;

    assign debug_data = mem[debug_addr];

    debug_dump_reader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .halt       (halt),
        .step_req   (step_req),
        .debug_en   (debug_en),
        .debug_step (debug_step),
        .debug_addr (debug_addr),
        .debug_data (debug_data),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .done       (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // Byte capture, stall stability and in-dump invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", {31'b0, tx_valid}, 32'd1);
                chk("stall_data", {24'b0, tx_data}, {24'b0, prev_data});
            end
            if (tx_valid && tx_ready) got.push_back(tx_data);
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            if (busy) begin
                chk("busy_step", {31'b0, debug_step}, 32'd0);
                chk("busy_en", {31'b0, debug_en}, 32'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        case (ready_mode)
            1:       tx_ready = ~tx_ready;
            2:       tx_ready = 1'($urandom_range(0, 1));
            3:       tx_ready = ((cyc % 40) >= 20);
            default: tx_ready = 1'b1;
        endcase
    endtask

    task automatic fill(input bit rnd);
        for (int a = 0; a < 128; a++) begin
            logic [6:0] a7;
            a7 = 7'(a);
            mem[a] = rnd ? $urandom() : {8'hDE, 8'hAD, 1'b0, a7, 8'h00};
        end
    endtask

    task automatic build_expected();
        logic [7:0] x;
        logic [7:0] b;
        exp_q.delete();
        x = 8'h00;
        if (FRAME) begin
            exp_q.push_back(8'hA5);
            exp_q.push_back(8'h5A);
        end
        for (int a = LO; a <= HI; a++) begin
            for (int k = 3; k >= 0; k--) begin
                b = 8'(mem[a] >> (8 * k));
                exp_q.push_back(b);
                x ^= b;
            end
        end
        if (FRAME) exp_q.push_back(x);
    endtask

    task automatic run_dump(input bit inject, input string tag);
        int n;
        int m;
        bit seen;
        got.delete();
        build_expected();
        start    = 1'b1;
        step_req = inject;
        tick();
        start    = 1'b0;
        step_req = 1'b0;
        chk({tag, "_busy_on"}, {31'b0, busy}, 32'd1);
        chk({tag, "_addr_first"}, {25'b0, debug_addr}, LO);
        if (inject) chk("start_step_drop", {31'b0, debug_step}, 32'd0);
        n = 1;
        seen = done;
        while (!seen && n < 20000) begin
            start    = inject && (n == 100);
            step_req = inject && (n == 150);
            tick();
            n++;
            start    = 1'b0;
            step_req = 1'b0;
            seen     = done;
        end
        chk({tag, "_done_seen"}, {31'b0, seen}, 32'd1);
        chk({tag, "_busy_at_done"}, {31'b0, busy}, 32'd1);
        if (ready_mode == 0) chk({tag, "_latency"}, n, LAT);
        tick();
        chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
        chk({tag, "_busy_off"}, {31'b0, busy}, 32'd0);
        chk({tag, "_addr_back"}, {25'b0, debug_addr}, LO);
        chk({tag, "_valid_off"}, {31'b0, tx_valid}, 32'd0);
        chk({tag, "_nbytes"}, got.size(), exp_q.size());
        m = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < m; i++)
            chk($sformatf("%s_byte%0d", tag, i), {24'b0, got[i]}, {24'b0, exp_q[i]});
    endtask

`ifdef DEBUG_DUMP_FRAME_EN
    logic       f_start, f_en, f_step, f_valid, f_busy, f_done;
    logic [6:0] f_addr;
    logic [7:0] f_data;
    logic [7:0] f_got[$];

    debug_dump_reader #(.ADDR_FIRST(5), .ADDR_LAST(5)) u_frm (
        .clk        (clk),
        .rst        (rst),
        .start      (f_start),
        .halt       (1'b0),
        .step_req   (1'b0),
        .debug_en   (f_en),
        .debug_step (f_step),
        .debug_addr (f_addr),
        .debug_data (32'h12345678),
        .tx_data    (f_data),
        .tx_valid   (f_valid),
        .tx_ready   (1'b1),
        .busy       (f_busy),
        .done       (f_done)
    );

    always @(negedge clk) if (!rst && f_valid) f_got.push_back(f_data);
`endif

    initial begin
        int n;
        logic [7:0] fexp [7];
        rst = 1'b0; start = 1'b0; halt = 1'b0; step_req = 1'b0; tx_ready = 1'b1;
`ifdef DEBUG_DUMP_FRAME_EN
        f_start = 1'b0;
`endif
        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 1'b0, 1'b1, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0};
        fill(1'b0);

        // Asynchronous reset mid-cycle: outputs must settle before any edge.
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_addr", {25'b0, debug_addr}, LO);
        chk("rst_valid", {31'b0, tx_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_step", {31'b0, debug_step}, 32'd0);
        chk("rst_data", {24'b0, tx_data}, 32'd0);
        chk("rst_en", {31'b0, debug_en}, 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            step_req = tbl[i].step;
            halt     = tbl[i].hlt;
            tick();
            step_req = 1'b0;
            chk($sformatf("step_vec%0d", i), {31'b0, debug_step}, {31'b0, tbl[i].exp_step});
            chk($sformatf("en_vec%0d", i), {31'b0, debug_en}, {31'b0, tbl[i].exp_en});
        end
        halt = 1'b0;

        ready_mode = 0;
        run_dump(1'b1, "full");
        if (got.size() >= 4 * WORDS)
            chk("last_word_addr", {24'b0, got[4 * WORDS - 2 + (FRAME ? 2 : 0)]}, 32'h3F);

        ready_mode = 1;
        fill(1'b1);
        run_dump(1'b0, "toggle");

        ready_mode = 3;
        fill(1'b1);
        run_dump(1'b0, "stall");

        // Reset in the middle of a dump, then a clean dump from address LO.
        ready_mode = 2;
        fill(1'b1);
        got.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (got.size() < 50 && n < 5000) begin
            tick();
            n++;
        end
        chk("mid_reach50", {31'b0, got.size() >= 50}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'b0, tx_valid}, 32'd0);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_addr", {25'b0, debug_addr}, LO);
        @(negedge clk);
        #1 rst = 1'b0;
        tick();
        run_dump(1'b0, "after_rst");

`ifdef DEBUG_DUMP_FRAME_EN
        fexp = '{8'hA5, 8'h5A, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
        f_got.delete();
        f_start = 1'b1;
        tick();
        f_start = 1'b0;
        n = 0;
        while (!f_done && n < 200) begin
            tick();
            n++;
        end
        chk("frm_done", {31'b0, f_done}, 32'd1);
        chk("frm_nbytes", f_got.size(), 32'd7);
        for (int i = 0; i < 7; i++)
            if (i < f_got.size())
                chk($sformatf("frm_byte%0d", i), {24'b0, f_got[i]}, {24'b0, fexp[i]});
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
